// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction sequencer for the SimpleCPU core.
// Drives the PC next-value input every cycle and strobes IR, ALU and RF write.
//
// Ports:
//   clk      in   1  system clock, rising edge
//   reset    in   1  asynchronous, active-low
//   start    in   1  leave IDLE/HALT
//   stall    in   1  freeze sequencing for this cycle
//   pc       in   4  current program counter
//   instr    in   8  instruction word, [7:4] opcode, [3:0] imm
//   zero     in   1  ALU zero flag, used by JZ in EXEC
//   pc_next  out  4  value the PC loads on the next edge
//   pc_load  out  1  pc_next carries a new target (WB)
//   ir_load  out  1  instruction register load strobe (FETCH)
//   alu_en   out  1  ALU execute strobe (EXEC, ALU ops)
//   reg_we   out  1  register-file write strobe (WB, ALU ops)
//   halted   out  1  in HALT
//   retired  out  8  completed-instruction count, wraps
module pc_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stall,
    input  logic [3:0] pc,
    input  logic [7:0] instr,
    input  logic       zero,
    output logic [3:0] pc_next,
    output logic       pc_load,
    output logic       ir_load,
    output logic       alu_en,
    output logic       reg_we,
    output logic       halted,
    output logic [7:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_JZ  = 4'hC;
    localparam logic [3:0] OP_JR  = 4'hD;
    localparam logic [3:0] OP_JMP = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t     state;
    state_t     state_nx;
    logic [3:0] pc_base;
    logic [3:0] op;
    logic [3:0] imm;
    logic [3:0] target;
    logic [3:0] target_nx;
    logic       is_alu;
    logic       is_hlt;

    assign is_alu = (op != OP_NOP) && (op < OP_JZ);
    assign is_hlt = (op == OP_HLT);

    // Target is resolved in EXEC so that zero only matters in that cycle.
    // A plain 4-bit add of imm equals adding its sign-extended value mod 16.
    always_comb begin
        target_nx = pc_base + 4'd2;
        case (op)
            OP_JZ:   target_nx = zero ? imm : pc_base + 4'd2;
            OP_JR:   target_nx = pc_base + imm;
            OP_JMP:  target_nx = imm;
            default: target_nx = pc_base + 4'd2;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        if (!stall) begin
            case (state)
                S_IDLE:   if (start) state_nx = S_FETCH;
                S_FETCH:  state_nx = S_DECODE;
                S_DECODE: state_nx = S_EXEC;
                S_EXEC:   state_nx = is_hlt ? S_HALT : S_WB;
                S_WB:     state_nx = S_FETCH;
                S_HALT:   if (start) state_nx = S_FETCH;
                default:  state_nx = S_IDLE;
            endcase
        end
    end

    // Datapath latches and retire counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_base <= 4'h0;
            op      <= 4'h0;
            imm     <= 4'h0;
            target  <= 4'h0;
            retired <= 8'h00;
        end else if (!stall) begin
            case (state)
                S_FETCH: pc_base <= pc;
                S_DECODE: begin
                    op  <= instr[7:4];
                    imm <= instr[3:0];
                end
                S_EXEC: begin
                    target <= target_nx;
                    if (is_hlt) retired <= retired + 8'd1;
                end
                S_WB: retired <= retired + 8'd1;
                default: ;
            endcase
        end
    end

    // Output logic; a stalled cycle suppresses every strobe.
    always_comb begin
        ir_load = 1'b0;
        alu_en  = 1'b0;
        reg_we  = 1'b0;
        pc_load = 1'b0;
        pc_next = pc;
        halted  = (state == S_HALT);
        if (!stall) begin
            case (state)
                S_FETCH: ir_load = 1'b1;
                S_EXEC:  alu_en  = is_alu;
                S_WB: begin
                    pc_load = 1'b1;
                    reg_we  = is_alu;
                    pc_next = target;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized bench for pc_sequencer.
// Models the PC register externally and checks against instruction-level rules.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       stall = 1'b0;
    logic       zero = 1'b0;
    logic [7:0] instr = 8'h00;
    logic [3:0] pc_r = 4'h0;
    logic       pc_ovr = 1'b0;
    logic [3:0] pc_ovr_val = 4'h0;
    logic [3:0] pc;
    logic [3:0] pc_next;
    logic       pc_load;
    logic       ir_load;
    logic       alu_en;
    logic       reg_we;
    logic       halted;
    logic [7:0] retired;

    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] m_ret = 8'h00;
    logic [3:0] m_pc = 4'h0;

    assign pc = pc_ovr ? pc_ovr_val : pc_r;

    pc_sequencer dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .stall   (stall),
        .pc      (pc),
        .instr   (instr),
        .zero    (zero),
        .pc_next (pc_next),
        .pc_load (pc_load),
        .ir_load (ir_load),
        .alu_en  (alu_en),
        .reg_we  (reg_we),
        .halted  (halted),
        .retired (retired)
    );

    always #5 clk = ~clk;

    // The program counter register the sequencer feeds.
    always @(posedge clk) pc_r <= pc_next;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [3:0] ref_target(input logic [3:0] p,
                                              input logic [7:0] ins,
                                              input logic z);
        int op;
        int imm;
        int r;
        op  = int'(ins[7:4]);
        imm = int'(ins[3:0]);
        if (op == 12)      r = z ? imm : int'(p) + 2;
        else if (op == 13) r = int'(p) + (imm >= 8 ? imm - 16 : imm) + 16;
        else if (op == 14) r = imm;
        else               r = int'(p) + 2;
        return 4'(r % 16);
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic quiet(input string ph);
        chk({ph, "/strobes"}, {ir_load, alu_en, reg_we, pc_load}, 4'b0000);
        chk({ph, "/hold"}, pc_next, pc);
    endtask

    task automatic stalls(input int n, input string ph);
        repeat (n) begin
            stall = 1'b1;
            #1 quiet(ph);
            step();
        end
        stall = 1'b0;
    endtask

    // Entered at a negedge with the DUT in FETCH.
    task automatic run_instr(input logic [7:0] ins, input logic z,
                             input int pcv, input int sf, input int sd,
                             input int se, input int sw,
                             output logic did_halt);
        logic       alu;
        logic [3:0] base;
        logic [3:0] tgt;
        alu = (ins[7:4] >= 4'h1) && (ins[7:4] <= 4'hB);
        if (pcv >= 0) begin
            pc_ovr     = 1'b1;
            pc_ovr_val = 4'(pcv);
            m_pc       = 4'(pcv);
        end
        instr = 8'($urandom);
        zero  = 1'($urandom);
        stalls(sf, "fetch");
        #1 chk("fetch/strobes", {ir_load, alu_en, reg_we, pc_load}, 4'b1000);
        chk("fetch/hold", pc_next, pc);
        base = m_pc;
        step();
        pc_ovr = 1'b0;
        instr = ins;
        stalls(sd, "decode");
        #1 quiet("decode");
        step();
        instr = 8'($urandom);
        zero = ~z;
        stalls(se, "exec");
        zero = z;
        #1 chk("exec/strobes", {ir_load, alu_en, reg_we, pc_load},
               {1'b0, alu, 2'b00});
        chk("exec/hold", pc_next, pc);
        tgt = ref_target(base, ins, z);
        step();
        zero = 1'($urandom);
        if (ins[7:4] == 4'hF) begin
            m_ret++;
            #1 chk("hlt/halted", halted, 1);
            chk("hlt/retired", retired, m_ret);
            quiet("hlt");
            did_halt = 1'b1;
        end else begin
            stalls(sw, "wb");
            #1 chk("wb/strobes", {ir_load, alu_en, reg_we, pc_load},
                   {2'b00, alu, 1'b1});
            chk("wb/pc_next", pc_next, tgt);
            step();
            m_ret++;
            m_pc = tgt;
            #1 chk("next/pc", pc, m_pc);
            chk("retired", retired, m_ret);
            chk("halted", halted, 0);
            did_halt = 1'b0;
        end
    endtask

    task automatic halt_hold(input int n);
        repeat (n) begin
            start = 1'b0;
            stall = 1'($urandom);
            #1 chk("halt/halted", halted, 1);
            quiet("halt");
            chk("halt/pc", pc, m_pc);
            step();
        end
        stall = 1'b0;
    endtask

    task automatic resume();
        start = 1'b1;
        stall = 1'b1;
        #1 quiet("resume/stall");
        chk("resume/stall_halted", halted, 1);
        step();
        stall = 1'b0;
        #1 chk("resume/halted", halted, 1);
        step();
        start = 1'b0;
        chk("resume/pc", pc, m_pc);
    endtask

    function automatic int rnd_stall();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
    endfunction

    initial begin
        logic       h;
        logic [7:0] ins;
        int         pcv;

        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1 quiet("reset");
        chk("reset/retired", retired, 0);
        chk("reset/halted", halted, 0);
        @(negedge clk);
        reset = 1'b1;
        step();

        // start while stalled must not leave IDLE
        start = 1'b1;
        stall = 1'b1;
        #1 quiet("idle/stall");
        step();
        start = 1'b0;
        stall = 1'b0;
        #1 quiet("idle/hold");
        step();
        start = 1'b1;
        #1 quiet("idle/start");
        step();
        start = 1'b0;

        run_instr(8'h35, 1'b0, 4, 0, 0, 0, 0, h);
        run_instr(8'h00, 1'b0, 14, 0, 0, 0, 0, h);
        run_instr(8'hDC, 1'b0, 2, 0, 0, 0, 0, h);
        run_instr(8'hEA, 1'b0, 2, 0, 0, 0, 0, h);
        run_instr(8'hC9, 1'b0, 4, 0, 0, 0, 0, h);
        run_instr(8'hC9, 1'b1, 4, 0, 0, 0, 0, h);
        run_instr(8'hF0, 1'b0, -1, 0, 0, 0, 0, h);
        halt_hold(10);
        resume();
        run_instr(8'h5A, 1'b0, -1, 0, 2, 0, 0, h);
        run_instr(8'hC3, 1'b1, -1, 1, 1, 2, 1, h);

        for (int i = 0; i < 300; i++) begin
            ins = 8'($urandom);
            if (ins[7:4] == 4'hF && $urandom_range(0, 3) != 0)
                ins[7:4] = 4'($urandom_range(0, 14));
            pcv = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : -1;
            run_instr(ins, 1'($urandom), pcv, rnd_stall(), rnd_stall(),
                      rnd_stall(), rnd_stall(), h);
            if (h) begin
                halt_hold(int'($urandom_range(1, 4)));
                resume();
            end
        end

        // reset in the middle of EXEC abandons the instruction
        #1 chk("rst/fetch", ir_load, 1);
        step();
        instr = 8'h35;
        #1 quiet("rst/decode");
        step();
        #1 chk("rst/exec_alu", alu_en, 1);
        reset = 1'b0;
        #1 quiet("rst/async");
        chk("rst/retired", retired, 0);
        chk("rst/halted", halted, 0);
        step();
        #1 quiet("rst/held");
        @(negedge clk);
        reset = 1'b1;
        m_ret = 8'h00;
        #1 quiet("rst/idle");
        step();
        #1 quiet("rst/idle2");
        chk("rst/retired2", retired, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        m_pc = pc_r;
        run_instr(8'h12, 1'b0, 9, 0, 0, 0, 0, h);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
